// File: rtl/yuv422to444_interp.sv
// 4:2:2 -> 4:4:4 chroma upsampler with optional odd-pixel chroma interpolation.
// Each packed YUYV input beat is emitted as two 4:4:4 output beats. In
// interpolation mode a beat is held until its successor arrives, so the last
// odd pixel can average against the next beat's first chroma pair.
module yuv422to444_interp #(
  parameter int          DATA_WIDTH = 64,
  parameter logic [7:0]  ALPHA      = 8'h00
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    interp,
  input  logic                    src_t_valid,
  output logic                    src_t_ready,
  input  logic [DATA_WIDTH-1:0]   src_t_data,
  input  logic                    src_t_last,
  output logic                    dst_t_valid,
  input  logic                    dst_t_ready,
  output logic [DATA_WIDTH-1:0]   dst_t_data,
  output logic                    dst_t_last,
  output logic [DATA_WIDTH/8-1:0] dst_t_keep
);

  localparam int PAIRS = DATA_WIDTH / 32;

  typedef enum logic [1:0] {
    S_EMPTY,
    S_WAIT,
    S_EMIT0,
    S_EMIT1
  } state_t;

  state_t state, state_next;

  logic [DATA_WIDTH-1:0] cur_data, nxt_data;
  logic                  cur_last, nxt_last;
  logic                  mode;

  logic load_cur, load_nxt, advance;
  logic emit_valid;
  logic [DATA_WIDTH-1:0] emit_data;

  logic [7:0]  u_arr [PAIRS+1];
  logic [7:0]  v_arr [PAIRS+1];
  logic [31:0] pix   [2*PAIRS];

  // Rounded average of two chroma samples, 9-bit intermediate so 255+255 cannot wrap.
  function automatic logic [7:0] avg8(input logic [7:0] a, input logic [7:0] b);
    return 8'(({1'b0, a} + {1'b0, b} + 9'd1) >> 1);
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_EMPTY;
    else     state <= state_next;
  end

  // Next-state logic, handshake outputs and buffer load strobes.
  always_comb begin
    state_next  = state;
    load_cur    = 1'b0;
    load_nxt    = 1'b0;
    advance     = 1'b0;
    src_t_ready = 1'b0;
    emit_valid  = 1'b0;
    dst_t_last  = 1'b0;
    case (state)
      S_EMPTY: begin
        src_t_ready = 1'b1;
        if (src_t_valid) begin
          load_cur   = 1'b1;
          state_next = (!interp || src_t_last) ? S_EMIT0 : S_WAIT;
        end
      end
      S_WAIT: begin
        src_t_ready = 1'b1;
        if (src_t_valid) begin
          load_nxt   = 1'b1;
          state_next = S_EMIT0;
        end
      end
      S_EMIT0: begin
        emit_valid = 1'b1;
        if (dst_t_ready) state_next = S_EMIT1;
      end
      S_EMIT1: begin
        emit_valid = 1'b1;
        dst_t_last = cur_last;
        if (dst_t_ready) begin
          if (!mode || cur_last) begin
            state_next = S_EMPTY;
          end else begin
            advance    = 1'b1;
            state_next = nxt_last ? S_EMIT0 : S_WAIT;
          end
        end
      end
      default: state_next = S_EMPTY;
    endcase
    // Handshake outputs are forced quiet for the whole reset cycle.
    if (rst) begin
      src_t_ready = 1'b0;
      emit_valid  = 1'b0;
      dst_t_last  = 1'b0;
      load_cur    = 1'b0;
      load_nxt    = 1'b0;
      advance     = 1'b0;
    end
  end

  // Beat buffers and latched line mode.
  always_ff @(posedge clk) begin
    if (rst) begin
      cur_data <= '0;
      cur_last <= 1'b0;
      nxt_data <= '0;
      nxt_last <= 1'b0;
      mode     <= 1'b0;
    end else begin
      if (load_cur) begin
        cur_data <= src_t_data;
        cur_last <= src_t_last;
        mode     <= interp;
      end
      if (load_nxt) begin
        nxt_data <= src_t_data;
        nxt_last <= src_t_last;
      end
      if (advance) begin
        cur_data <= nxt_data;
        cur_last <= nxt_last;
      end
    end
  end

  // Chroma per pair; the extra slot is the right-hand neighbour of the last
  // pair (next beat's first pair, or a copy of the last pair at line end).
  always_comb begin
    for (int unsigned k = 0; k < PAIRS; k++) begin
      u_arr[k] = cur_data[32*k+8  +: 8];
      v_arr[k] = cur_data[32*k+24 +: 8];
    end
    if (cur_last) begin
      u_arr[PAIRS] = cur_data[32*(PAIRS-1)+8  +: 8];
      v_arr[PAIRS] = cur_data[32*(PAIRS-1)+24 +: 8];
    end else begin
      u_arr[PAIRS] = nxt_data[15:8];
      v_arr[PAIRS] = nxt_data[31:24];
    end
  end

  // Expand each pair into two 4:4:4 pixels {ALPHA, v, u, y}.
  always_comb begin
    for (int unsigned k = 0; k < PAIRS; k++) begin
      pix[2*k]   = {ALPHA, v_arr[k], u_arr[k], cur_data[32*k +: 8]};
      if (mode)
        pix[2*k+1] = {ALPHA, avg8(v_arr[k], v_arr[k+1]), avg8(u_arr[k], u_arr[k+1]),
                      cur_data[32*k+16 +: 8]};
      else
        pix[2*k+1] = {ALPHA, v_arr[k], u_arr[k], cur_data[32*k+16 +: 8]};
    end
  end

  // Select the half of the pixel row belonging to the current output beat.
  always_comb begin
    for (int unsigned p = 0; p < PAIRS; p++) begin
      if (state == S_EMIT1) emit_data[32*p +: 32] = pix[PAIRS+p];
      else                  emit_data[32*p +: 32] = pix[p];
    end
  end

  // Output stream drive; data and keep read zero whenever not valid.
  always_comb begin
    dst_t_valid = emit_valid;
    dst_t_data  = emit_valid ? emit_data : '0;
    dst_t_keep  = emit_valid ? '1 : '0;
  end

endmodule

// File: tb/tb_yuv422to444_interp.sv
// Directed bench for yuv422to444_interp at DATA_WIDTH=64.
module tb_yuv422to444_interp;

  logic        clk = 1'b0;
  logic        rst;
  logic        interp;
  logic        src_t_valid;
  logic        src_t_ready;
  logic [63:0] src_t_data;
  logic        src_t_last;
  logic        dst_t_valid;
  logic        dst_t_ready;
  logic [63:0] dst_t_data;
  logic        dst_t_last;
  logic [7:0]  dst_t_keep;

  int checks = 0;
  int errors = 0;

  yuv422to444_interp #(.DATA_WIDTH(64), .ALPHA(8'h00)) dut (
    .clk         (clk),
    .rst         (rst),
    .interp      (interp),
    .src_t_valid (src_t_valid),
    .src_t_ready (src_t_ready),
    .src_t_data  (src_t_data),
    .src_t_last  (src_t_last),
    .dst_t_valid (dst_t_valid),
    .dst_t_ready (dst_t_ready),
    .dst_t_data  (dst_t_data),
    .dst_t_last  (dst_t_last),
    .dst_t_keep  (dst_t_keep)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a beat and hold it until accepted (bounded).
  task automatic send_beat(input logic [63:0] data, input logic last);
    src_t_valid = 1'b1;
    src_t_data  = data;
    src_t_last  = last;
    for (int i = 0; i < 20; i++) begin
      if (src_t_ready) break;
      step();
    end
    check("src_accept", 64'(src_t_ready), 64'd1);
    step();
    src_t_valid = 1'b0;
  endtask

  // Wait (bounded) for an output beat, check it, and consume it.
  task automatic expect_out(input string tag, input logic [63:0] data, input logic last);
    for (int i = 0; i < 20; i++) begin
      if (dst_t_valid) break;
      step();
    end
    check({tag, "_valid"}, 64'(dst_t_valid), 64'd1);
    check({tag, "_data"},  dst_t_data, data);
    check({tag, "_last"},  64'(dst_t_last), 64'(last));
    check({tag, "_keep"},  64'(dst_t_keep), 64'hff);
    step();
  endtask

  initial begin
    rst = 1'b1; interp = 1'b0; src_t_valid = 1'b0; src_t_data = '0;
    src_t_last = 1'b0; dst_t_ready = 1'b1;
    step(); step();
    check("rst_src_ready", 64'(src_t_ready), 64'd0);
    check("rst_dst_valid", 64'(dst_t_valid), 64'd0);
    check("rst_dst_data",  dst_t_data, 64'd0);
    check("rst_dst_last",  64'(dst_t_last), 64'd0);
    rst = 1'b0;
    #1;
    check("post_rst_ready", 64'(src_t_ready), 64'd1);

    // Replicate mode, single last beat.
    interp = 1'b0;
    send_beat(64'h08070605_04030201, 1'b1);
    check("rep_latency", 64'(dst_t_valid), 64'd1);
    check("rep_src_busy", 64'(src_t_ready), 64'd0);
    expect_out("rep_h0", 64'h00040203_00040201, 1'b0);
    expect_out("rep_h1", 64'h00080607_00080605, 1'b1);

    // Interp mode, single last beat: final odd pixel edge-replicated.
    interp = 1'b1;
    send_beat(64'h08070605_04030201, 1'b1);
    check("int1_latency", 64'(dst_t_valid), 64'd1);
    expect_out("int1_h0", 64'h00060403_00040201, 1'b0);
    expect_out("int1_h1", 64'h00080607_00080605, 1'b1);

    // Interp across beats; interp dropped mid-line must not matter.
    interp = 1'b1;
    send_beat(64'h08070605_04030201, 1'b0);
    interp = 1'b0;
    check("ab_hold0", 64'(dst_t_valid), 64'd0);
    step();
    check("ab_hold1", 64'(dst_t_valid), 64'd0);
    check("ab_wait_ready", 64'(src_t_ready), 64'd1);
    send_beat(64'h14150a13_14120a11, 1'b1);
    check("ab_latency", 64'(dst_t_valid), 64'd1);
    expect_out("a_h0", 64'h00060403_00040201, 1'b0);
    expect_out("a_h1", 64'h000e0807_00080605, 1'b0);
    check("b_direct", 64'(dst_t_valid), 64'd1);
    expect_out("b_h0", 64'h00140a12_00140a11, 1'b0);
    expect_out("b_h1", 64'h00140a15_00140a13, 1'b1);

    // Backpressure in EMIT1.
    interp = 1'b0;
    dst_t_ready = 1'b0;
    send_beat(64'h08070605_04030201, 1'b1);
    dst_t_ready = 1'b1;
    check("bp_h0_data", dst_t_data, 64'h00040203_00040201);
    step();
    dst_t_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", 64'(dst_t_valid), 64'd1);
      check("bp_data",  dst_t_data, 64'h00080607_00080605);
      check("bp_last",  64'(dst_t_last), 64'd1);
      check("bp_src_ready", 64'(src_t_ready), 64'd0);
      step();
    end
    dst_t_ready = 1'b1;
    expect_out("bp_h1", 64'h00080607_00080605, 1'b1);
    check("bp_done", 64'(src_t_ready), 64'd1);

    // Rounding: (255,255)->255, (0,1)->1, (2,5)->4.
    interp = 1'b1;
    send_beat(64'h0124ff23_0022ff21, 1'b1);
    expect_out("rnd1_h0", 64'h0001ff22_0000ff21, 1'b0);
    expect_out("rnd1_h1", 64'h0001ff24_0001ff23, 1'b1);
    send_beat(64'h02340533_05320231, 1'b1);
    expect_out("rnd2_h0", 64'h00040432_00050231, 1'b0);
    expect_out("rnd2_h1", 64'h00020534_00020533, 1'b1);

    // Reset while a beat is buffered in WAIT.
    interp = 1'b1;
    send_beat(64'h08070605_04030201, 1'b0);
    check("wr_in_wait", 64'(src_t_ready), 64'd1);
    rst = 1'b1;
    #1;
    check("wr_rst_ready", 64'(src_t_ready), 64'd0);
    check("wr_rst_valid", 64'(dst_t_valid), 64'd0);
    check("wr_rst_data",  dst_t_data, 64'd0);
    step();
    rst = 1'b0;
    #1;
    check("wr_post_ready", 64'(src_t_ready), 64'd1);
    check("wr_post_valid", 64'(dst_t_valid), 64'd0);
    step();
    check("wr_no_stale", 64'(dst_t_valid), 64'd0);
    send_beat(64'h14150a13_14120a11, 1'b1);
    check("wr_latency", 64'(dst_t_valid), 64'd1);
    expect_out("wr_h0", 64'h00140a12_00140a11, 1'b0);
    expect_out("wr_h1", 64'h00140a15_00140a13, 1'b1);
    check("wr_idle", 64'(dst_t_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
